// File: rtl/flap_position_sequencer.sv
// Flap position sequencer.
// Two requesters share the flap indicator. Manual requests have fixed priority
// over auto requests. The block mirrors the indicator position and issues
// forward-only step pulses, spaced by a mechanical settle interval.
module flap_position_sequencer #(
    parameter int unsigned STEP_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       async_nreset,
    input  logic       manual_valid,
    input  logic [1:0] manual_target,
    output logic       manual_ready,
    input  logic       auto_valid,
    input  logic [1:0] auto_target,
    output logic       auto_ready,
    output logic       change_position_re,
    output logic [1:0] position,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       last_src
);

    localparam int unsigned      CNT_W    = $clog2(STEP_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(STEP_CYCLES - 1);
    localparam logic [1:0]       POS_DOWN = 2'd2;
    localparam logic [1:0]       POS_BAD  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_GAP,
        S_FINISH,
        S_REJECT
    } state_t;

    state_t           state, state_next;
    logic [1:0]       remaining, remaining_next;
    logic [CNT_W-1:0] count, count_next;
    logic [1:0]       position_next;
    logic             last_src_next;

    logic             manual_accept;
    logic             auto_accept;
    logic             accept;
    logic [1:0]       req_target;
    logic [1:0]       req_steps;

    // Forward steps needed to go from 'from' to 'target' on the 3-position ring.
    function automatic logic [1:0] steps_to(input logic [1:0] target,
                                            input logic [1:0] from);
        logic [2:0] diff;
        diff = {1'b0, target} + 3'd3 - {1'b0, from};
        if (diff >= 3'd3) begin
            diff = diff - 3'd3;
        end
        return diff[1:0];
    endfunction

    assign manual_ready  = (state == S_IDLE);
    assign auto_ready    = (state == S_IDLE) & ~manual_valid;
    assign manual_accept = manual_valid & manual_ready;
    assign auto_accept   = auto_valid & auto_ready;
    assign accept        = manual_accept | auto_accept;
    assign req_target    = manual_accept ? manual_target : auto_target;
    assign req_steps     = steps_to(req_target, position);

    // Next-state logic: arbitration, step sequencing and the settle countdown.
    always_comb begin
        // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
        state_next     = state;
        remaining_next = remaining;
        count_next     = count;
        position_next  = position;
        last_src_next  = last_src;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    last_src_next = auto_accept;
                    if (req_target == POS_BAD) begin
                        state_next = S_REJECT;
                    end else if (req_steps == 2'd0) begin
                        state_next = S_FINISH;
                    end else begin
                        state_next     = S_PULSE;
                        remaining_next = req_steps;
                    end
                end
            end
            S_PULSE: begin
                position_next  = (position == POS_DOWN) ? 2'd0 : position + 2'd1;
                remaining_next = remaining - 2'd1;
                count_next     = GAP_LOAD;
                state_next     = S_GAP;
            end
            S_GAP: begin
                if (count == CNT_W'(1)) begin
                    state_next = (remaining != 2'd0) ? S_PULSE : S_FINISH;
                end else begin
                    count_next = count - 1'b1;
                end
            end
            S_FINISH: state_next = S_IDLE;
            S_REJECT: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // State and datapath registers. Outputs are decoded from the next state so that each output comes straight from a flop.
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            state              <= S_IDLE;
            remaining          <= 2'd0;
            count              <= '0;
            position           <= 2'd0;
            last_src           <= 1'b0;
            change_position_re <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            err                <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample the pre-edge values, which matches the flops being built.
            state              <= state_next;
            remaining          <= remaining_next;
            count              <= count_next;
            position           <= position_next;
            last_src           <= last_src_next;
            change_position_re <= (state_next == S_PULSE);
            busy               <= (state_next != S_IDLE);
            done               <= (state_next == S_FINISH);
            err                <= (state_next == S_REJECT);
        end
    end

endmodule

// File: tb/tb_flap_position_sequencer.sv
// Directed testbench for flap_position_sequencer with STEP_CYCLES=4.
// The cycle numbers below count from the accepting edge: cycle c is the
// interval after the c-th rising edge that follows acceptance.
module tb_flap_position_sequencer;

    localparam int unsigned STEP = 4;

    logic       clk;
    logic       async_nreset;
    logic       manual_valid;
    logic [1:0] manual_target;
    logic       manual_ready;
    logic       auto_valid;
    logic [1:0] auto_target;
    logic       auto_ready;
    logic       change_position_re;
    logic [1:0] position;
    logic       busy;
    logic       done;
    logic       err;
    logic       last_src;

    int checks   = 0;
    int failures = 0;
    logic prev_pulse = 1'b0;

    flap_position_sequencer #(.STEP_CYCLES(STEP)) dut (
        .clk                (clk),
        .async_nreset       (async_nreset),
        .manual_valid       (manual_valid),
        .manual_target      (manual_target),
        .manual_ready       (manual_ready),
        .auto_valid         (auto_valid),
        .auto_target        (auto_target),
        .auto_ready         (auto_ready),
        .change_position_re (change_position_re),
        .position           (position),
        .busy               (busy),
        .done               (done),
        .err                (err),
        .last_src           (last_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Invariants on every cycle outside reset.
    always @(negedge clk) begin
        if (async_nreset) begin
            checks++;
            if (done && err) begin
                failures++;
                $display("FAIL excl_done_err: done=%b err=%b both high", done, err);
            end
            checks++;
            if (change_position_re && prev_pulse) begin
                failures++;
                $display("FAIL pulse_spacing: pulse high in consecutive cycles");
            end
        end
        prev_pulse = change_position_re;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fields in the packed compares: {pulse,done,err,busy,ready,pos[1:0],last_src}.
    task automatic test_reset();
        checks++;
        if ({change_position_re, done, err, busy, last_src, position} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs: got {pulse,done,err,busy,src,pos}=%b want 0000000",
                     {change_position_re, done, err, busy, last_src, position});
        end
        checks++;
        if ({manual_ready, auto_ready} !== 2'b11) begin
            failures++;
            $display("FAIL reset_ready: got {m,a}=%b want 11", {manual_ready, auto_ready});
        end
        async_nreset = 1'b1;
        tick();
        checks++;
        if ({busy, change_position_re, position} !== 4'b0) begin
            failures++;
            $display("FAIL reset_release: got {busy,pulse,pos}=%b want 0000",
                     {busy, change_position_re, position});
        end
    endtask

    // Auto request UP -> DOWN: two steps.
    task automatic test_two_step();
        logic [7:0] exp, got;
        logic [1:0] exp_pos;
        auto_target = 2'd2;
        auto_valid  = 1'b1;
        tick();
        auto_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            exp_pos = (c <= 1) ? 2'd0 : (c <= 5) ? 2'd1 : 2'd2;
            exp = {(c == 1) || (c == 5), c == 9, 1'b0, c <= 9, c >= 10, exp_pos, 1'b1};
            got = {change_position_re, done, err, busy, auto_ready, position, last_src};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL two_step c=%0d: got %b want %b", c, got, exp);
            end
            if (c < 10) tick();
        end
    endtask

    // Manual request DOWN -> UP: one step.
    task automatic test_one_step();
        logic [7:0] exp, got;
        manual_target = 2'd0;
        manual_valid  = 1'b1;
        tick();
        manual_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            exp = {c == 1, c == 5, 1'b0, c <= 5, c >= 6, (c <= 1) ? 2'd2 : 2'd0, 1'b0};
            got = {change_position_re, done, err, busy, manual_ready, position, last_src};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL one_step c=%0d: got %b want %b", c, got, exp);
            end
            if (c < 6) tick();
        end
    endtask

    // Both requesters at once: manual UP -> HORIZONTAL first, then auto to HORIZONTAL (zero steps).
    task automatic test_priority();
        logic [7:0] exp, got;
        manual_target = 2'd1;
        auto_target   = 2'd1;
        manual_valid  = 1'b1;
        auto_valid    = 1'b1;
        #1;
        checks++;
        if ({manual_ready, auto_ready} !== 2'b10) begin
            failures++;
            $display("FAIL prio_ready: got {m,a}=%b want 10", {manual_ready, auto_ready});
        end
        tick();
        manual_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 7) auto_valid = 1'b0;
            exp = {c == 1, (c == 5) || (c == 7), 1'b0, (c <= 5) || (c == 7),
                   (c == 6) || (c == 8), (c <= 1) ? 2'd0 : 2'd1, c >= 7};
            got = {change_position_re, done, err, busy, auto_ready, position, last_src};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL priority c=%0d: got %b want %b", c, got, exp);
            end
            if (c < 8) tick();
        end
    endtask

    // Manual request to the invalid target 3 while at HORIZONTAL.
    task automatic test_invalid();
        logic [7:0] exp, got;
        manual_target = 2'd3;
        manual_valid  = 1'b1;
        tick();
        manual_valid = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            exp = {1'b0, 1'b0, c == 1, c == 1, c == 2, 2'd1, 1'b0};
            got = {change_position_re, done, err, busy, manual_ready, position, last_src};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL invalid c=%0d: got %b want %b", c, got, exp);
            end
            if (c < 2) tick();
        end
    endtask

    // Auto request for the current position (HORIZONTAL): done with no pulse.
    task automatic test_same_target();
        logic [7:0] exp, got;
        auto_target = 2'd1;
        auto_valid  = 1'b1;
        tick();
        auto_valid = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            exp = {1'b0, c == 1, 1'b0, c == 1, c == 2, 2'd1, 1'b1};
            got = {change_position_re, done, err, busy, auto_ready, position, last_src};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL same_target c=%0d: got %b want %b", c, got, exp);
            end
            if (c < 2) tick();
        end
    endtask

    // Two-step move HORIZONTAL -> UP aborted by reset between the pulses.
    task automatic test_reset_abort();
        manual_target = 2'd0;
        manual_valid  = 1'b1;
        tick();
        manual_valid = 1'b0;
        checks++;
        if ({change_position_re, position} !== 3'b101) begin
            failures++;
            $display("FAIL abort_first_pulse: got {pulse,pos}=%b want 101", {change_position_re, position});
        end
        tick();
        checks++;
        if ({change_position_re, busy, position} !== 4'b0110) begin
            failures++;
            $display("FAIL abort_gap: got {pulse,busy,pos}=%b want 0110", {change_position_re, busy, position});
        end
        #2;
        async_nreset = 1'b0;
        #1;
        checks++;
        if ({change_position_re, done, err, busy, manual_ready, position} !== 7'b0000100) begin
            failures++;
            $display("FAIL abort_in_reset: got {pulse,done,err,busy,ready,pos}=%b want 0000100",
                     {change_position_re, done, err, busy, manual_ready, position});
        end
        tick();
        tick();
        async_nreset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if ({change_position_re, done, err, busy, position} !== 6'b0) begin
                failures++;
                $display("FAIL abort_quiet i=%0d: got {pulse,done,err,busy,pos}=%b want 000000",
                         i, {change_position_re, done, err, busy, position});
            end
        end
    endtask

    // Fresh auto request UP -> HORIZONTAL after the aborted move.
    task automatic test_after_reset();
        logic [7:0] exp, got;
        auto_target = 2'd1;
        auto_valid  = 1'b1;
        tick();
        auto_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            exp = {c == 1, c == 5, 1'b0, c <= 5, c >= 6, (c <= 1) ? 2'd0 : 2'd1, 1'b1};
            got = {change_position_re, done, err, busy, auto_ready, position, last_src};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL after_reset c=%0d: got %b want %b", c, got, exp);
            end
            if (c < 6) tick();
        end
    endtask

    initial begin
        async_nreset  = 1'b0;
        manual_valid  = 1'b0;
        manual_target = 2'd0;
        auto_valid    = 1'b0;
        auto_target   = 2'd0;
        tick();
        tick();
        test_reset();
        test_two_step();
        test_one_step();
        test_priority();
        test_invalid();
        test_same_target();
        test_reset_abort();
        test_after_reset();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
